// File: rtl/axi4lite_pkg.sv
// Shared response codes and FSM state types for the AXI4-Lite memory responder.
// The delay states exist only when AXI4LITE_MEM_DELAY_EN is defined.
package axi4lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    W_IDLE,
    W_HAVE_AW,
    W_HAVE_W,
`ifdef AXI4LITE_MEM_DELAY_EN
    W_DELAY,
`endif
    W_RESP
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
`ifdef AXI4LITE_MEM_DELAY_EN
    R_DELAY,
`endif
    R_RESP
  } rd_state_t;

endpackage

// File: rtl/axi4lite_if.sv
// AXI4-Lite bus bundle: five channels with master and slave views.
interface axi4lite_if #(
  parameter int unsigned ADDR_W = 32
);

  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;

  logic              wvalid;
  logic              wready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;

  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;

  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;

  logic              rvalid;
  logic              rready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

endinterface

// File: rtl/axi4lite_delay_cnt.sv
// Response wait counter: load starts counting, done pulses DELAY cycles after load.
// Only compiled when AXI4LITE_MEM_DELAY_EN is defined.
`ifdef AXI4LITE_MEM_DELAY_EN
module axi4lite_delay_cnt #(
  parameter int unsigned DELAY = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic done
);

  logic [31:0] cnt;
  logic        busy;

  // cnt reaches DELAY on the DELAY-th cycle after load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= 32'd0;
      busy <= 1'b0;
    end else if (load) begin
      cnt  <= 32'd1;
      busy <= (DELAY != 0);
    end else if (done) begin
      cnt  <= 32'd0;
      busy <= 1'b0;
    end else if (busy) begin
      cnt  <= cnt + 32'd1;
    end
  end

  assign done = busy && (cnt == DELAY);

endmodule
`endif

// File: rtl/axi4lite_mem_slave.sv
// AXI4-Lite memory responder: independent read/write FSMs over a DEPTH x 32 array.
// Define AXI4LITE_MEM_DELAY_EN to insert DELAY wait cycles ahead of each response.
module axi4lite_mem_slave
  import axi4lite_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned DELAY     = 3
) (
  input  logic      clk,
  input  logic      rst_n,
  axi4lite_if.slave bus
);

  localparam int unsigned     IDX_W     = $clog2(DEPTH);
  localparam logic [ADDR_W:0] BASE_EXT  = (ADDR_W+1)'(BASE_ADDR);
  localparam logic [ADDR_W:0] LIMIT_EXT = BASE_EXT + (ADDR_W+1)'(4 * DEPTH);

  // One extra bit keeps the window limit from wrapping near the top of the map
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} >= BASE_EXT) && ({1'b0, a} < LIMIT_EXT);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'(({1'b0, a} - BASE_EXT) >> 2);
  endfunction

  logic [31:0] mem [DEPTH];

  wr_state_t         w_state, w_next;
  rd_state_t         r_state, r_next;
  logic              aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic              write_commit;
  logic [ADDR_W-1:0] aw_addr_q, commit_addr;
  logic [31:0]       w_data_q, commit_data;
  logic [3:0]        w_strb_q, commit_strb;
  logic [1:0]        bresp_q, rresp_q;
  logic [31:0]       rdata_q;

  assign aw_hs = bus.awvalid & bus.awready;
  assign w_hs  = bus.wvalid  & bus.wready;
  assign b_hs  = bus.bvalid  & bus.bready;
  assign ar_hs = bus.arvalid & bus.arready;
  assign r_hs  = bus.rvalid  & bus.rready;

`ifdef AXI4LITE_MEM_DELAY_EN
  logic w_delay_done, r_delay_done;

  localparam wr_state_t W_AFTER = (DELAY == 0) ? W_RESP : W_DELAY;
  localparam rd_state_t R_AFTER = (DELAY == 0) ? R_RESP : R_DELAY;

  axi4lite_delay_cnt #(.DELAY(DELAY)) u_w_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (write_commit),
    .done  (w_delay_done)
  );

  axi4lite_delay_cnt #(.DELAY(DELAY)) u_r_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (ar_hs),
    .done  (r_delay_done)
  );
`else
  localparam wr_state_t W_AFTER = W_RESP;
  localparam rd_state_t R_AFTER = R_RESP;

  logic unused_delay;
  assign unused_delay = ^DELAY;
`endif

  // Write commits on whichever handshake completes the AW/W pair
  assign write_commit = ((w_state == W_IDLE)    && aw_hs && w_hs) ||
                        ((w_state == W_HAVE_AW) && w_hs)          ||
                        ((w_state == W_HAVE_W)  && aw_hs);

  assign commit_addr = (w_state == W_HAVE_AW) ? aw_addr_q : bus.awaddr;
  assign commit_data = (w_state == W_HAVE_W)  ? w_data_q  : bus.wdata;
  assign commit_strb = (w_state == W_HAVE_W)  ? w_strb_q  : bus.wstrb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) w_state <= W_IDLE;
    else        w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs) w_next = W_AFTER;
        else if (aw_hs)    w_next = W_HAVE_AW;
        else if (w_hs)     w_next = W_HAVE_W;
      end
      W_HAVE_AW: if (w_hs)  w_next = W_AFTER;
      W_HAVE_W:  if (aw_hs) w_next = W_AFTER;
`ifdef AXI4LITE_MEM_DELAY_EN
      W_DELAY:   if (w_delay_done) w_next = W_RESP;
`endif
      W_RESP:    if (b_hs)  w_next = W_IDLE;
      default:   w_next = W_IDLE;
    endcase
  end

  always_comb begin
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    bus.bvalid  = 1'b0;
    case (w_state)
      W_IDLE: begin
        bus.awready = 1'b1;
        bus.wready  = 1'b1;
      end
      W_HAVE_AW: bus.wready  = 1'b1;
      W_HAVE_W:  bus.awready = 1'b1;
      W_RESP:    bus.bvalid  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_addr_q <= '0;
      w_data_q  <= 32'd0;
      w_strb_q  <= 4'd0;
      bresp_q   <= RESP_OKAY;
    end else begin
      if (aw_hs) aw_addr_q <= bus.awaddr;
      if (w_hs) begin
        w_data_q <= bus.wdata;
        w_strb_q <= bus.wstrb;
      end
      if (write_commit) bresp_q <= in_range(commit_addr) ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Storage is never reset; writes are blocked while reset is held
  always_ff @(posedge clk) begin
    if (rst_n && write_commit && in_range(commit_addr)) begin
      for (int i = 0; i < 4; i++) begin
        if (commit_strb[i]) mem[word_idx(commit_addr)][8*i +: 8] <= commit_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= R_IDLE;
    else        r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_AFTER;
`ifdef AXI4LITE_MEM_DELAY_EN
      R_DELAY: if (r_delay_done) r_next = R_RESP;
`endif
      R_RESP:  if (r_hs) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    case (r_state)
      R_IDLE:  bus.arready = 1'b1;
      R_RESP:  bus.rvalid  = 1'b1;
      default: ;
    endcase
  end

  // Read data samples the array before any same-edge write lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= 32'd0;
      rresp_q <= RESP_OKAY;
    end else if (ar_hs) begin
      if (in_range(bus.araddr)) begin
        rdata_q <= mem[word_idx(bus.araddr)];
        rresp_q <= RESP_OKAY;
      end else begin
        rdata_q <= 32'd0;
        rresp_q <= RESP_SLVERR;
      end
    end
  end

  assign bus.bresp = bresp_q;
  assign bus.rdata = rdata_q;
  assign bus.rresp = rresp_q;

endmodule

// File: doc/axi4lite_mem_slave.md
AXI4LITE_MEM_SLAVE -- requirements
Module: axi4lite_mem_slave

Interface
REQ-001 Parameter ADDR_W, default 32, address width of AW/AR channels.
REQ-002 Parameter DEPTH, default 1024, memory size in 32-bit words (power of two).
REQ-003 Parameter BASE_ADDR, default 32'h8000_0000, byte address of word 0.
REQ-004 Parameter DELAY, default 3, extra response cycles (used only with macro, REQ-030).
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 awvalid/awready  in/out  1/1, awaddr  in  ADDR_W  -- write address channel.
REQ-008 wvalid/wready  in/out  1/1, wdata  in  32, wstrb  in  4  -- write data channel.
REQ-009 bvalid/bready  out/in  1/1, bresp  out  2  -- write response channel.
REQ-010 arvalid/arready  in/out  1/1, araddr  in  ADDR_W  -- read address channel.
REQ-011 rvalid/rready  out/in  1/1, rdata  out  32, rresp  out  2  -- read data channel.

Function
REQ-012 Block SHALL be an AXI4-Lite responder backed by DEPTH x 32 storage; read and write paths SHALL be independent and concurrent.
REQ-013 Handshake on any channel SHALL occur only in a cycle with valid and ready both high.
REQ-014 Write FSM states: W_IDLE, W_HAVE_AW, W_HAVE_W, W_DELAY, W_RESP.
REQ-015 W_IDLE: awready=1, wready=1; AW-only -> W_HAVE_AW; W-only -> W_HAVE_W; both same cycle -> write performed, then W_RESP (W_DELAY with macro).
REQ-016 W_HAVE_AW: awready=0, wready=1; W handshake -> write, W_RESP. W_HAVE_W mirrors this with awready=1, wready=0.
REQ-017 Write SHALL update only byte lanes with wstrb[i]=1; wstrb=4'b0000 SHALL leave memory unchanged, still respond OKAY.
REQ-018 Word index = (addr - BASE_ADDR) >> 2; addr[1:0] ignored.
REQ-019 Address below BASE_ADDR or at/above BASE_ADDR+4*DEPTH SHALL return SLVERR (2'b10), no memory write; in-range SHALL return OKAY (2'b00).
REQ-020 W_RESP: bvalid=1, awready=wready=0; bvalid/bresp held stable until bready; on handshake -> W_IDLE.
REQ-021 Read FSM states: R_IDLE (arready=1), R_DELAY, R_RESP (rvalid=1, arready=0).
REQ-022 On AR handshake rdata/rresp SHALL be captured from memory as of that cycle (pre-write value if a write commits the same edge); out-of-range -> rdata=0, SLVERR.
REQ-023 rvalid/rdata/rresp SHALL be held stable until rready; on handshake -> R_IDLE; no new AR accepted in that cycle.
REQ-024 Latency without macro: AR handshake cycle N -> rvalid in N+1; final AW/W handshake cycle N -> bvalid in N+1.
REQ-025 Throughput: one outstanding read and one outstanding write at most.

Reset
REQ-026 On rst_n low, both FSMs SHALL enter idle immediately; bvalid=rvalid=0, bresp=rresp=2'b00, rdata=0, delay counters 0.
REQ-027 After reset release awready=wready=arready=1 in first cycle.
REQ-028 Memory contents SHALL NOT be reset; reset mid-transaction SHALL discard latched address/data and any pending response without writing memory.

Configuration
REQ-029 Macro AXI4LITE_MEM_DELAY_EN controls response delay.
REQ-030 With macro: W_DELAY/R_DELAY hold DELAY cycles before valid, latency N+1+DELAY; without: delay states absent, REQ-024 latency.

Structure
REQ-031 Package axi4lite_pkg SHALL hold resp constants (RESP_OKAY=2'b00, RESP_SLVERR=2'b10) and write/read FSM state typedefs.
REQ-032 Sub-module axi4lite_delay_cnt (load, count to DELAY, done pulse) instantiated per channel only under macro.

Verification
REQ-033 AW+W same cycle addr 0x8000_0010 data 0xDEADBEEF strb 4'hF, bready=1 -> bvalid next cycle, OKAY; read back 0xDEADBEEF, rvalid one cycle after AR.
REQ-034 W 3 cycles before AW, strb 4'b0101 data 0x11223344 over 0xFFFFFFFF -> word reads 0xFF22FF44; awready low while waiting? no, wready low until B.
REQ-035 araddr 0x7FFF_FFFC and awaddr 0x8000_1000 (DEPTH=1024) -> SLVERR, rdata=0, memory unchanged.
REQ-036 bready/rready held low 5 cycles -> bvalid/rvalid, bresp, rdata stable all 5 cycles; ready signals of AW/W/AR low.
REQ-037 Write and read same address same cycle (old 0x1, new 0x2) -> read returns 0x1, next read 0x2.
REQ-038 rst_n asserted in W_HAVE_AW -> bvalid 0, memory unchanged; with macro, DELAY=3 -> rvalid 4 cycles after AR.
